// File: rtl/nes_reset_pkg.sv
// Shared definitions for the NES core reset tree: the FSM state encoding,
// the default timing constants and the bit order of the reset vector.
`timescale 1ns/1ps
package nes_reset_pkg;

    // 3-bit FSM encoding, also exported on the debug state port
    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_REL_CLK  = 3'd1,
        ST_REL_MCU  = 3'd2,
        ST_REL_PPU  = 3'd3,
        ST_REL_CPU  = 3'd4,
        ST_RUN      = 3'd5,
        ST_BTN_WAIT = 3'd6,
        ST_SOFT     = 3'd7
    } state_t;

    // Default timing, in i_clk cycles
    localparam int DEF_POR_CYCLES       = 1024;
    localparam int DEF_STAGE_GAP_CYCLES = 16;
    localparam int DEF_DEBOUNCE_CYCLES  = 65536;
    localparam int DEF_CNT_W            = 17;

    // Reset vector, active-low, bit order {cpu, ppu, mcu, clk}
    typedef logic [3:0] rst_vec_t;

    localparam int RST_CLK = 0;
    localparam int RST_MCU = 1;
    localparam int RST_PPU = 2;
    localparam int RST_CPU = 3;

    // Every domain held in reset
    localparam rst_vec_t RST_ALL_ASSERTED = 4'b0000;
    // Soft reset: the MCU keeps running, everything else is held
    localparam rst_vec_t RST_SOFT_HOLD    = 4'b0010;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with a selectable reset value, so each
// input can come out of reset in its own inactive state.
`timescale 1ns/1ps
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic d,
    output logic q
);

    logic stage_p0;
    logic stage_p1;

    // Two-flop chain; the first flop may go metastable, the second settles it
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            stage_p0 <= RESET_VAL;
            stage_p1 <= RESET_VAL;
        end else begin
            stage_p0 <= d;
            stage_p1 <= stage_p0;
        end
    end

    assign q = stage_p1;

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset tree for the NES core. Combines power-on reset, PLL lock,
// the front-panel button and MCU soft-reset requests, and releases the
// domains in the order clock generator, MCU, PPU, CPU. Resets assert
// asynchronously through i_reset_n and deassert on i_clk from flops only.
`timescale 1ns/1ps
module reset_sequencer
    import nes_reset_pkg::*;
#(
    parameter int POR_CYCLES       = DEF_POR_CYCLES,
    parameter int STAGE_GAP_CYCLES = DEF_STAGE_GAP_CYCLES,
    parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
    // 2**CNT_W must exceed both POR_CYCLES and DEBOUNCE_CYCLES
    parameter int CNT_W            = DEF_CNT_W
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_pll_locked,
    input  logic       i_button_n,
    input  logic       i_soft_reset_req,
    output logic       o_soft_reset_ack,
    output logic       o_reset_clk_n,
    output logic       o_reset_mcu_n,
    output logic       o_reset_ppu_n,
    output logic       o_reset_cpu_n,
    output logic [2:0] o_state,
    output logic       o_busy
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(STAGE_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic pll;
    logic btn_n;
    logic req;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] low_cnt;
    rst_vec_t         rst_vec;
    logic             busy;

    logic press;
    logic gap_done;
    logic release_phase;

    sync_2ff #(.RESET_VAL(1'b0)) u_sync_pll (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .d         (i_pll_locked),
        .q         (pll)
    );

    sync_2ff #(.RESET_VAL(1'b1)) u_sync_btn (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .d         (i_button_n),
        .q         (btn_n)
    );

    sync_2ff #(.RESET_VAL(1'b0)) u_sync_req (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .d         (i_soft_reset_req),
        .q         (req)
    );

    // A press is the button seen low on the sample that completes the
    // debounce window; the low-time counter is kept separate from the
    // sequencing counter so presses are caught during release staging too.
    assign press    = !btn_n && (low_cnt == DEB_LAST);
    assign gap_done = (cnt == GAP_LAST);

    assign release_phase = (state == ST_REL_CLK) || (state == ST_REL_MCU) ||
                           (state == ST_REL_PPU) || (state == ST_REL_CPU) ||
                           (state == ST_RUN);

    // Ack is a decode of flopped signals: high for the single cycle in which
    // the FSM is in RUN and is about to take the request (PLL loss and button
    // press win over it).
    assign o_soft_reset_ack = (state == ST_RUN) && pll && !press && req;

    // Button-low time: any high sample clears, saturates at the press point
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            low_cnt <= '0;
        end else if (btn_n) begin
            low_cnt <= '0;
        end else if (low_cnt != DEB_LAST) begin
            low_cnt <= low_cnt + CNT_ONE;
        end
    end

    // Sequencing FSM with registered reset vector and busy flag
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= ST_HOLD;
            cnt     <= '0;
            rst_vec <= RST_ALL_ASSERTED;
            busy    <= 1'b1;
        end else if ((state != ST_HOLD) && !pll) begin
            state   <= ST_HOLD;
            cnt     <= '0;
            rst_vec <= RST_ALL_ASSERTED;
            busy    <= 1'b1;
        end else if (release_phase && press) begin
            state   <= ST_BTN_WAIT;
            cnt     <= '0;
            rst_vec <= RST_ALL_ASSERTED;
            busy    <= 1'b1;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (!pll) begin
                        cnt <= '0;
                    end else if (cnt == POR_LAST) begin
                        state            <= ST_REL_CLK;
                        cnt              <= '0;
                        rst_vec[RST_CLK] <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_REL_CLK: begin
                    if (gap_done) begin
                        state            <= ST_REL_MCU;
                        cnt              <= '0;
                        rst_vec[RST_MCU] <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_REL_MCU: begin
                    if (gap_done) begin
                        state            <= ST_REL_PPU;
                        cnt              <= '0;
                        rst_vec[RST_PPU] <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_REL_PPU: begin
                    if (gap_done) begin
                        state            <= ST_REL_CPU;
                        cnt              <= '0;
                        rst_vec[RST_CPU] <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_REL_CPU: begin
                    if (gap_done) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    cnt <= '0;
                    if (req) begin
                        state   <= ST_SOFT;
                        rst_vec <= RST_SOFT_HOLD;
                        busy    <= 1'b1;
                    end
                end
                ST_SOFT: begin
                    // Rejoin the staged release at the MCU step; the MCU
                    // release there is a no-op because it never went low.
                    if (gap_done) begin
                        state            <= ST_REL_MCU;
                        cnt              <= '0;
                        rst_vec[RST_CLK] <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_BTN_WAIT: begin
                    if (!btn_n) begin
                        cnt <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state <= ST_HOLD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state   <= ST_HOLD;
                    cnt     <= '0;
                    rst_vec <= RST_ALL_ASSERTED;
                    busy    <= 1'b1;
                end
            endcase
        end
    end

    assign o_reset_clk_n = rst_vec[RST_CLK];
    assign o_reset_mcu_n = rst_vec[RST_MCU];
    assign o_reset_ppu_n = rst_vec[RST_PPU];
    assign o_reset_cpu_n = rst_vec[RST_CPU];
    assign o_state       = state;
    assign o_busy        = busy;

endmodule
